// File: rtl/shreg_norm_ctrl.sv
// Normalisation sequencer for a load/shift-right register: loads the operand,
// then shifts right until the upper half is zero or the shift limit is reached.
module shreg_norm_ctrl #(
  parameter int N         = 16,
  parameter int CNT_W     = 5,
  parameter int MAX_SHIFT = N / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             half,
  input  logic             mid,
  output logic             ld,
  output logic             shr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             mid_seen,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SHIFT);

  state_t state;
  logic   at_limit;

  assign at_limit = (shift_cnt == CNT_MAX);

  // shr must act in the same cycle the register reports its flags, so it is
  // decoded from the current state rather than registered.
  assign shr = (state == SHIFT) && !half && !at_limit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ld        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shift_cnt <= '0;
      mid_seen  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ld   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            ld        <= 1'b1;
            busy      <= 1'b1;
            shift_cnt <= '0;
            mid_seen  <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        LOAD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (mid) mid_seen <= 1'b1;
          if (half) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (at_limit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ovf   <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_norm_ctrl.sv
// Bench for shreg_norm_ctrl: models the 16-bit shift register around the
// sequencer and compares each operation against a closed-form result model.
module tb_shreg_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        half;
  logic        mid;
  logic        ld;
  logic        shr;
  logic        busy;
  logic        done;
  logic [4:0]  shift_cnt;
  logic        mid_seen;
  logic        ovf;

  logic [15:0] sreg = 16'h0000;
  logic [15:0] load_val = 16'h0000;
  logic        force0 = 1'b0;

  int total = 0;
  int bad   = 0;

  shreg_norm_ctrl #(.N(16), .CNT_W(5), .MAX_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .half(half), .mid(mid),
    .ld(ld), .shr(shr), .busy(busy), .done(done),
    .shift_cnt(shift_cnt), .mid_seen(mid_seen), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign half = force0 ? 1'b0 : (sreg[15:8] == 8'h00);
  assign mid  = sreg[9];

  always @(posedge clk) begin
    if (ld) sreg <= load_val;
    else if (shr) sreg <= sreg >> 1;
  end

  // Closed-form result: shifts needed to bring v below 256, clipped at 8.
  task automatic model(input logic [15:0] v, input logic f,
                       output int k, output logic ms, output logic ov);
    int need;
    logic [31:0] vv;
    vv = {16'h0, v};
    need = 0;
    while ((vv >> need) > 32'h0000_00FF) need++;
    if (f) need = 99;
    k  = (need > 8) ? 8 : need;
    ov = (need > 8);
    ms = |((vv >> 9) & ((32'h1 << (k + 1)) - 32'h1));
  endtask

  task automatic run_op(input logic [15:0] v, input logic f, input logic noisy,
                        input string name);
    int k, n, nld, nshr;
    logic ms, ov, seen;
    logic [15:0] fin;
    model(v, f, k, ms, ov);
    fin = v >> k;
    load_val = v;
    force0 = f;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; nld = 0; nshr = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (ld) nld++;
      if (shr) nshr++;
      total++;
      if (busy !== (n <= 2 + k)) begin
        bad++;
        $display("FAIL %s busy cyc%0d got=%b exp=%b", name, n, busy, (n <= 2 + k));
      end
      total++;
      if ((ld & shr) !== 1'b0) begin
        bad++;
        $display("FAIL %s ld_shr_overlap cyc%0d got=1 exp=0", name, n);
      end
      if (done) seen = 1'b1;
      else if (noisy && busy) start = 1'($urandom % 2);
      else start = 1'b0;
    end
    start = 1'b0;
    total++;
    if (!seen || n != 3 + k) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d (seen=%b)", name, n, 3 + k, seen);
    end
    total++;
    if (nld != 1) begin bad++; $display("FAIL %s ld_count got=%0d exp=1", name, nld); end
    total++;
    if (nshr != k) begin bad++; $display("FAIL %s shr_count got=%0d exp=%0d", name, nshr, k); end
    total++;
    if (shift_cnt !== 5'(k)) begin
      bad++; $display("FAIL %s shift_cnt got=%0d exp=%0d", name, shift_cnt, k);
    end
    total++;
    if (mid_seen !== ms) begin bad++; $display("FAIL %s mid_seen got=%b exp=%b", name, mid_seen, ms); end
    total++;
    if (ovf !== ov) begin bad++; $display("FAIL %s ovf got=%b exp=%b", name, ovf, ov); end
    total++;
    if (sreg !== fin) begin bad++; $display("FAIL %s reg got=%h exp=%h", name, sreg, fin); end
    @(negedge clk);
    total++;
    if ({done, busy, shift_cnt, ovf} !== {1'b0, 1'b0, 5'(k), ov}) begin
      bad++;
      $display("FAIL %s hold got=%b%b/%0d/%b exp=00/%0d/%b", name, done, busy, shift_cnt, ovf, k, ov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ld, shr, busy, done, shift_cnt, mid_seen, ovf} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {ld, shr, busy, done, shift_cnt, mid_seen, ovf});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(16'h00FF, 1'b0, 1'b0, "no_shift");
    run_op(16'h0300, 1'b0, 1'b0, "two_shift");
    run_op(16'h8000, 1'b0, 1'b0, "eight_shift");
    run_op(16'h00FF, 1'b1, 1'b0, "forced_ovf");
  endtask

  task automatic test_busy_start();
    run_op(16'h8000, 1'b0, 1'b1, "start_while_busy");
    run_op(16'h1234, 1'b1, 1'b1, "start_while_busy_ovf");
  endtask

  task automatic test_back_to_back();
    int n, nld, ndone;
    force0 = 1'b0;
    load_val = 16'h0300;
    @(negedge clk);
    start = 1'b1;
    n = 0; nld = 0; ndone = 0;
    while (ndone < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (ld) begin
        nld++;
        if (nld == 2) begin
          total++;
          if (n != 7 || {shift_cnt, mid_seen, ovf} !== 7'b0) begin
            bad++;
            $display("FAIL b2b_second_ld got=cyc%0d/%0d/%b/%b exp=cyc7/0/0/0", n, shift_cnt, mid_seen, ovf);
          end
          start = 1'b0;
        end
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          total++;
          if (n != 5 || shift_cnt !== 5'd2 || mid_seen !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done got=cyc%0d/%0d/%b exp=cyc5/2/1", n, shift_cnt, mid_seen);
          end
        end
      end
    end
    start = 1'b0;
    total++;
    if (ndone != 2 || n != 11 || nld != 2) begin
      bad++;
      $display("FAIL b2b_second_done got=cyc%0d dones=%0d lds=%0d exp=cyc11 dones=2 lds=2", n, ndone, nld);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int n;
    force0 = 1'b0;
    load_val = 16'h8000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (shift_cnt != 5'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (shift_cnt !== 5'd3) begin
      bad++; $display("FAIL midreset_reach got=%0d exp=3", shift_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ld, shr, busy, done, shift_cnt, mid_seen, ovf} !== 11'b0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b exp=0", {ld, shr, busy, done, shift_cnt, mid_seen, ovf});
    end
    rst = 1'b1;
    @(negedge clk);
    run_op(16'h0300, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      logic f, nz;
      v  = 16'($urandom_range(0, 65535));
      f  = ($urandom % 5) == 0;
      nz = 1'($urandom % 2);
      run_op(v, f, nz, "random");
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    test_reset();
    test_directed();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
